notas_seq: RTL

NOTAS_SEQ -- requirements
Module: notas_seq

---
 rtl/notas_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/notas_seq.sv
// Note sequencer: buffers 4-bit note codes in a FIFO and plays them back with
// seven-segment display, note code output and square-wave tone generation.
module notas_seq #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NOTE_TICKS = 16,
    parameter int unsigned GAP_TICKS  = 4,
    parameter int unsigned TONE_BASE  = 8,
    parameter int unsigned TONE_STEP  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] note_in,
    input  logic       ready,
    input  logic       play,
    input  logic       stop,
    output logic [6:0] seg,
    output logic [3:0] note_out,
    output logic       tone,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       err
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned TMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int unsigned TKW  = $clog2(TMAX) + 1;
    localparam int unsigned TW   = $clog2(TONE_BASE + 2) + 1;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] CODE_REST = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [TKW-1:0]  tick, tick_nxt;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic [3:0]      mem [DEPTH];
    logic [3:0]      head;
    logic            push, pop, valid_code, is_full, is_empty;
    logic [3:0]      note_nxt;
    logic [6:0]      seg_nxt;
    logic            tone_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;

    function automatic logic [6:0] seg_map(input logic [3:0] code);
        case (code)
            4'd0:    seg_map = 7'b0111001;
            4'd1:    seg_map = 7'b1011110;
            4'd2:    seg_map = 7'b1111001;
            4'd3:    seg_map = 7'b1110001;
            4'd4:    seg_map = 7'b0111101;
            4'd5:    seg_map = 7'b1110111;
            4'd6:    seg_map = 7'b1111100;
            default: seg_map = SEG_BLANK;
        endcase
    endfunction

    // Half-period shrinks with pitch; clamped so high notes still toggle every cycle.
    function automatic logic [TW-1:0] half_period(input logic [3:0] code);
        int h;
        h = int'(TONE_BASE) - int'(TONE_STEP) * int'(code);
        if (h < 1) h = 1;
        half_period = TW'(h);
    endfunction

    assign head       = mem[rd_ptr];
    assign is_full    = (count == CW'(DEPTH));
    assign is_empty   = (count == '0);
    assign valid_code = (note_in <= 4'd6) || (note_in == CODE_REST);

    // Next-state, FIFO control and next registered outputs.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        pop       = 1'b0;
        note_nxt  = 4'd0;
        seg_nxt   = SEG_DASH;
        tone_nxt  = 1'b0;
        tcnt_nxt  = '0;

        case (state)
            S_IDLE: begin
                if (!stop && play && !is_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_PLAY;
                    tick_nxt  = '0;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (tick == TKW'(NOTE_TICKS - 1)) begin
                    state_nxt = S_GAP;
                    tick_nxt  = '0;
                end else begin
                    tick_nxt = tick + TKW'(1);
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (tick == TKW'(GAP_TICKS - 1)) begin
                    tick_nxt = '0;
                    if (!is_empty) begin
                        pop       = 1'b1;
                        state_nxt = S_PLAY;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    tick_nxt = tick + TKW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A simultaneous pop frees the slot the incoming note lands in.
        push = ready && valid_code && (!is_full || pop);

        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        if (state_nxt == S_PLAY) begin
            note_nxt = pop ? head : note_out;
            seg_nxt  = seg_map(note_nxt);
            if (!pop && note_out != CODE_REST) begin
                if (tcnt == half_period(note_out) - TW'(1)) begin
                    tone_nxt = ~tone;
                    tcnt_nxt = '0;
                end else begin
                    tone_nxt = tone;
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
        end else if (state_nxt == S_GAP) begin
            seg_nxt = SEG_BLANK;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tick     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            note_out <= 4'd0;
            seg      <= SEG_DASH;
            tone     <= 1'b0;
            tcnt     <= '0;
            busy     <= 1'b0;
            full     <= 1'b0;
            empty    <= 1'b1;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick     <= tick_nxt;
            count    <= count_nxt;
            note_out <= note_nxt;
            seg      <= seg_nxt;
            tone     <= tone_nxt;
            tcnt     <= tcnt_nxt;
            busy     <= (state_nxt != S_IDLE);
            full     <= (count_nxt == CW'(DEPTH));
            empty    <= (count_nxt == '0);
            err      <= ready && !push;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= note_in;
    end

endmodule
